// File: rtl/mmult_param.sv
// N x N matrix multiplier: one rank-1 update (column k of A times row k of B) per clock.
// A result appears N edges after start and is held until the consumer acks it.
module mmult_param #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = 2*DW+$clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N*N*DW-1:0]   A_mat,
  input  logic [N*N*DW-1:0]   B_mat,
  input  logic                signed_mode,
  input  logic                accumulate,
  input  logic                ack,
  output logic                busy,
  output logic                valid,
  output logic [N*N*OW-1:0]   C_mat
);

  localparam int NE = N*N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [DW-1:0] a_q [NE];
  logic [DW-1:0] b_q [NE];
  logic          sgn_q;
  logic [OW-1:0] c_q   [NE];
  logic [OW-1:0] c_nxt [NE];
  logic          accept;
  logic          last_k;

  function automatic logic signed [OW-1:0] extend(input logic [DW-1:0] v, input logic sgn);
    return {{(OW-DW){sgn & v[DW-1]}}, v};
  endfunction

  // Low OW bits of the product depend only on the low OW bits of the operands,
  // so multiplying the already-extended values gives the modulo-2^OW result.
  function automatic logic [OW-1:0] mac(input logic [OW-1:0] acc, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic sgn);
    logic signed [OW-1:0] p;
    p = extend(a, sgn) * extend(b, sgn);
    return acc + $unsigned(p);
  endfunction

  assign last_k = (k_q == KW'(N-1));
  assign accept = start && ((state_q == IDLE) || ((state_q == DONE) && ack));
  assign busy   = (state_q == COMPUTE);
  assign valid  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: if (last_k) state_d = DONE;
      DONE:    if (ack) state_d = start ? COMPUTE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    for (int e = 0; e < NE; e++) c_nxt[e] = c_q[e];
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c_nxt[i*N+j] = mac(c_q[i*N+j], a_q[i*N+int'(k_q)], b_q[int'(k_q)*N+j], sgn_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q   <= '0;
      sgn_q <= 1'b0;
      for (int e = 0; e < NE; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else if (accept) begin
      k_q   <= '0;
      sgn_q <= signed_mode;
      for (int e = 0; e < NE; e++) begin
        a_q[e] <= A_mat[(NE-1-e)*DW +: DW];
        b_q[e] <= B_mat[(NE-1-e)*DW +: DW];
        if (!accumulate) c_q[e] <= '0;
      end
    end else if (state_q == COMPUTE) begin
      k_q <= last_k ? '0 : k_q + KW'(1);
      for (int e = 0; e < NE; e++) c_q[e] <= c_nxt[e];
    end
  end

  always_comb begin
    C_mat = '0;
    for (int e = 0; e < NE; e++) C_mat[(NE-1-e)*OW +: OW] = c_q[e];
  end

endmodule
